// File: rtl/tetromino_mover_if.sv
// tetromino_mover_if: request/board inputs and live-piece outputs of tetromino_mover
// master: drives spawn/shape/tick/buttons/board, reads next_block*, placed, busy, game_over
// slave : the mover itself
interface tetromino_mover_if;
   logic         spawn;
   logic [2:0]   shape;
   logic         tick;
   logic         btn_left;
   logic         btn_right;
   logic         btn_rot;
   logic         btn_drop;
   logic [127:0] board;
   logic [2:0]   next_block1_x, next_block2_x, next_block3_x, next_block4_x;
   logic [3:0]   next_block1_y, next_block2_y, next_block3_y, next_block4_y;
   logic         placed;
   logic         busy;
   logic         game_over;
   modport master (
      output spawn, shape, tick, btn_left, btn_right, btn_rot, btn_drop, board,
      input  next_block1_x, next_block2_x, next_block3_x, next_block4_x,
             next_block1_y, next_block2_y, next_block3_y, next_block4_y,
             placed, busy, game_over
   );
   modport slave (
      input  spawn, shape, tick, btn_left, btn_right, btn_rot, btn_drop, board,
      output next_block1_x, next_block2_x, next_block3_x, next_block4_x,
             next_block1_y, next_block2_y, next_block3_y, next_block4_y,
             placed, busy, game_over
   );
endinterface

// File: rtl/tetromino_mover.sv
// tetromino_mover: live-piece position generator for an 8x16 Tetris playfield
// Ports: CLK (posedge), reset (async, active-low), bus (tetromino_mover_if.slave):
//   in  spawn/shape, tick, btn_left/right/rot/drop, board (bit y*8+x)
//   out next_block1..4_x/y (cell 2 = pivot), placed (active-low lock strobe),
//       busy (state != IDLE), game_over (sticky)
// Option: define TETROMINO_MOVER_HARD_DROP_EN to enable btn_drop hard drop.
module tetromino_mover (
   input logic CLK,
   input logic reset,
   tetromino_mover_if.slave bus
);
   typedef enum logic [2:0] {WAIT_SPAWN, IDLE, CALC, CHECK, LOCK, DEAD} state_t;
   typedef enum logic [2:0] {K_SPAWN, K_LEFT, K_RIGHT, K_DOWN, K_ROT} kind_t;
   state_t state;
   kind_t kind;
   logic [2:0] cur_x [4];
   logic [3:0] cur_y [4];
   logic signed [4:0] cand_x [4], cand_y [4], mv_x [4], mv_y [4];
   logic signed [4:0] px, py;
   logic [15:0] sp;
   logic [3:0] bad;
   logic is_o, tick_pend, placed, game_over;
`ifdef TETROMINO_MOVER_HARD_DROP_EN
   logic drop;
`endif
   // spawn table: four 3-bit x digits (cell1 first) followed by four 1-bit y values
   always_comb begin
      case (bus.shape)
         3'd0: sp = {12'o2345, 4'b0000};
         3'd2: sp = {12'o3454, 4'b0001};
         3'd3: sp = {12'o5434, 4'b0011};
         3'd4: sp = {12'o3445, 4'b0011};
         3'd5: sp = {12'o5433, 4'b0001};
         3'd6: sp = {12'o3455, 4'b0001};
         default: sp = {12'o3434, 4'b0011};
      endcase
   end
   assign px = $signed({2'b00, cur_x[1]});
   assign py = $signed({1'b0, cur_y[1]});
   for (genvar i = 0; i < 4; i++) begin : g_cell
      logic signed [4:0] x, y;
      assign x = $signed({2'b00, cur_x[i]});
      assign y = $signed({1'b0, cur_y[i]});
      // clockwise rotation about cell 2; the O piece rotates onto itself
      assign mv_x[i] = kind == K_LEFT ? x - 5'sd1 : kind == K_RIGHT ? x + 5'sd1 :
                       kind == K_ROT && !is_o ? px - (y - py) : x;
      assign mv_y[i] = kind == K_DOWN ? y + 5'sd1 : kind == K_ROT && !is_o ? py + (x - px) : y;
      // any of bits 4:3 set means x<0 or x>7; bit 4 of y means y<0 (y+1 never exceeds 16)
      assign bad[i] = |cand_x[i][4:3] | cand_y[i][4] | bus.board[{cand_y[i][3:0], cand_x[i][2:0]}];
   end
   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         state <= WAIT_SPAWN;
         kind <= K_SPAWN;
         is_o <= 1'b0;
         tick_pend <= 1'b0;
         placed <= 1'b1;
         game_over <= 1'b0;
`ifdef TETROMINO_MOVER_HARD_DROP_EN
         drop <= 1'b0;
`endif
         for (int i = 0; i < 4; i++) begin
            cur_x[i] <= '0;
            cur_y[i] <= '0;
            cand_x[i] <= '0;
            cand_y[i] <= '0;
         end
      end else begin
         if (bus.tick && state != IDLE && state != DEAD) tick_pend <= 1'b1;
         case (state)
            WAIT_SPAWN: if (bus.spawn) begin
               for (int i = 0; i < 4; i++) begin
                  cand_x[i] <= {2'b00, sp[15-3*i -: 3]};
                  cand_y[i] <= {4'b0000, sp[3-i]};
               end
               is_o <= bus.shape == 3'd1 || bus.shape == 3'd7;
               kind <= K_SPAWN;
               state <= CHECK;
            end
            IDLE: begin
`ifdef TETROMINO_MOVER_HARD_DROP_EN
               if (bus.btn_drop || drop) begin
                  drop <= 1'b1;
                  kind <= K_DOWN;
                  state <= CALC;
                  if (bus.tick) tick_pend <= 1'b1;
               end else
`endif
               if (bus.tick || tick_pend) begin
                  tick_pend <= 1'b0;
                  kind <= K_DOWN;
                  state <= CALC;
               end else if (bus.btn_left) begin
                  kind <= K_LEFT;
                  state <= CALC;
               end else if (bus.btn_right) begin
                  kind <= K_RIGHT;
                  state <= CALC;
               end else if (bus.btn_rot) begin
                  kind <= K_ROT;
                  state <= CALC;
               end
            end
            CALC: begin
               cand_x <= mv_x;
               cand_y <= mv_y;
               state <= CHECK;
            end
            CHECK: begin
               // a colliding spawn is still shown so the display can render the loss
               if (bad == 4'd0 || kind == K_SPAWN)
                  for (int i = 0; i < 4; i++) begin
                     cur_x[i] <= cand_x[i][2:0];
                     cur_y[i] <= cand_y[i][3:0];
                  end
               if (bad == 4'd0) state <= IDLE;
               else if (kind == K_SPAWN) begin
                  game_over <= 1'b1;
                  state <= DEAD;
               end else if (kind == K_DOWN) begin
                  placed <= 1'b0;
                  state <= LOCK;
`ifdef TETROMINO_MOVER_HARD_DROP_EN
                  drop <= 1'b0;
`endif
               end else state <= IDLE;
            end
            LOCK: begin
               placed <= 1'b1;
               state <= WAIT_SPAWN;
            end
            DEAD: state <= DEAD;
            default: state <= WAIT_SPAWN;
         endcase
      end
   end
   assign bus.next_block1_x = cur_x[0];
   assign bus.next_block2_x = cur_x[1];
   assign bus.next_block3_x = cur_x[2];
   assign bus.next_block4_x = cur_x[3];
   assign bus.next_block1_y = cur_y[0];
   assign bus.next_block2_y = cur_y[1];
   assign bus.next_block3_y = cur_y[2];
   assign bus.next_block4_y = cur_y[3];
   assign bus.placed = placed;
   assign bus.game_over = game_over;
   assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_tetromino_mover.sv
// tb_tetromino_mover: directed and random checks of tetromino_mover against a cell-list model
module tb_tetromino_mover;
   logic CLK = 1'b0;
   logic reset = 1'b0;
   tetromino_mover_if bus ();
   tetromino_mover dut (.CLK(CLK), .reset(reset), .bus(bus));
   always #5 CLK = ~CLK;
   int checks = 0;
   int errors = 0;
   int mx [4], my [4];
   int mshape = 0;
   bit live = 0, dead = 0;
   logic [127:0] mb = '0;
   assign bus.board = mb;
   int spx [8][4] = '{'{2,3,4,5}, '{3,4,3,4}, '{3,4,5,4}, '{5,4,3,4},
                      '{3,4,4,5}, '{5,4,3,3}, '{3,4,5,5}, '{3,4,3,4}};
   int spy [8][4] = '{'{0,0,0,0}, '{0,0,1,1}, '{0,0,0,1}, '{0,0,1,1},
                      '{0,0,1,1}, '{0,0,0,1}, '{0,0,0,1}, '{0,0,1,1}};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [27:0] dut_pack();
      return {bus.next_block1_x, bus.next_block1_y, bus.next_block2_x, bus.next_block2_y,
              bus.next_block3_x, bus.next_block3_y, bus.next_block4_x, bus.next_block4_y};
   endfunction
   function automatic logic [27:0] mpack();
      logic [27:0] r = '0;
      for (int i = 0; i < 4; i++) r = {r[20:0], 3'(mx[i]), 4'(my[i])};
      return r;
   endfunction
   function automatic bit fits(input int nx [4], input int ny [4]);
      for (int i = 0; i < 4; i++)
         if (nx[i] < 0 || nx[i] > 7 || ny[i] < 0 || ny[i] > 15 || mb[ny[i]*8 + nx[i]]) return 0;
      return 1;
   endfunction
   // k: 0 left, 1 right, 2 rotate, 3 down
   function automatic bit model_move(input int k);
      int nx [4], ny [4];
      for (int i = 0; i < 4; i++) begin
         nx[i] = mx[i] + (k == 0 ? -1 : k == 1 ? 1 : 0);
         ny[i] = my[i] + (k == 3 ? 1 : 0);
         if (k == 2 && mshape != 1 && mshape != 7) begin
            nx[i] = mx[1] - (my[i] - my[1]);
            ny[i] = my[1] + (mx[i] - mx[1]);
         end
      end
      if (!fits(nx, ny)) return 0;
      mx = nx;
      my = ny;
      return 1;
   endfunction
   task automatic set_req(input int k, input logic v);
      case (k)
         0: bus.btn_left = v;
         1: bus.btn_right = v;
         2: bus.btn_rot = v;
         3: bus.tick = v;
         default: bus.btn_drop = v;
      endcase
   endtask
   task automatic clear_inputs();
      bus.spawn = 0; bus.shape = 0; bus.tick = 0;
      bus.btn_left = 0; bus.btn_right = 0; bus.btn_rot = 0; bus.btn_drop = 0;
   endtask
   task automatic do_reset();
      reset = 0;
      clear_inputs();
      repeat (2) @(negedge CLK);
      reset = 1;
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin mx[i] = 0; my[i] = 0; end
      live = 0;
      dead = 0;
   endtask
   task automatic wait_idle(output int n);
      n = 0;
      for (int c = 1; c <= 8; c++) begin
         @(negedge CLK);
         if (!bus.busy) begin n = c; break; end
      end
   endtask
   task automatic do_spawn(input int s, input string tag);
      bit ok;
      int n = 0, lows = 0;
      mshape = s;
      mx = spx[s];
      my = spy[s];
      ok = fits(mx, my);
      bus.shape = 3'(s);
      bus.spawn = 1;
      for (int c = 1; c <= 6; c++) begin
         @(negedge CLK);
         bus.spawn = 0;
         lows += int'(!bus.placed);
         if (!bus.busy) begin n = c; break; end
      end
      chk({tag, " lat"}, n, ok ? 2 : 0);
      chk({tag, " placed"}, lows, 0);
      chk({tag, " game_over"}, bus.game_over, !ok);
      chk({tag, " cells"}, dut_pack(), mpack());
      live = ok;
      dead = !ok;
   endtask
   // k: 0 left, 1 right, 2 rotate, 3 tick, 4 hard drop
   task automatic do_req(input int k, input string tag);
      bit ok, locked;
      int n = 0, lows = 0, lim, steps = 0;
      lim = k == 4 ? 70 : 6;
      if (k == 4) begin
         while (model_move(3)) steps++;
         ok = 0;
      end else ok = model_move(k);
      locked = !ok && k >= 3;
      set_req(k, 1);
      for (int c = 1; c <= lim; c++) begin
         @(negedge CLK);
         set_req(k, 0);
         lows += int'(!bus.placed);
         if (!bus.busy) begin n = c; break; end
      end
      chk({tag, " lat"}, n, locked ? 0 : 3);
      chk({tag, " placed"}, lows, locked ? 1 : 0);
      chk({tag, " cells"}, dut_pack(), mpack());
      if (locked) begin
         live = 0;
         for (int i = 0; i < 4; i++) mb[my[i]*8 + mx[i]] = 1'b1;
      end
   endtask
   initial begin
      #600000;
      $fatal(1, "FAIL timeout: simulation did not finish");
   end
   initial begin
      int n, r;
      logic [27:0] e1;
      clear_inputs();
      repeat (3) @(negedge CLK);
      chk("rst cells", dut_pack(), 0);
      chk("rst placed", bus.placed, 1);
      chk("rst busy", bus.busy, 1);
      chk("rst game_over", bus.game_over, 0);
      reset = 1;
      @(negedge CLK);
      chk("wait_spawn busy", bus.busy, 1);
      do_spawn(2, "spawn_t");
      chk("spawn_t const", dut_pack(), {3'd3,4'd0,3'd4,4'd0,3'd5,4'd0,3'd4,4'd1});
      do_reset();
      do_spawn(0, "spawn_i");
      do_req(0, "i_left1");
      do_req(0, "i_left2");
      chk("i_left const", dut_pack(), {3'd0,4'd0,3'd1,4'd0,3'd2,4'd0,3'd3,4'd0});
      do_req(0, "i_left3");
      do_reset();
      do_spawn(1, "spawn_o");
      for (int t = 0; t < 20 && live; t++) do_req(3, "o_tick");
      chk("o_locked", live, 0);
      chk("o_bottom", dut_pack(), {3'd3,4'd14,3'd4,4'd14,3'd3,4'd15,3'd4,4'd15});
      do_spawn(3, "respawn_s");
      do_reset();
      mb = '0;
      mb[20] = 1'b1;
      do_spawn(2, "rot_spawn");
      do_req(2, "rot_blk");
      mb[20] = 1'b0;
      do_req(2, "rot_oob");
      do_req(3, "rot_tick");
      mb[4] = 1'b1;
      do_req(2, "rot_col");
      mb[4] = 1'b0;
      do_req(2, "rot_ok");
      chk("rot_ok const", dut_pack(), {3'd4,4'd0,3'd4,4'd1,3'd4,4'd2,3'd3,4'd1});
      do_reset();
      do_spawn(2, "pri_spawn");
      void'(model_move(3));
      bus.tick = 1;
      bus.btn_right = 1;
      @(negedge CLK);
      bus.tick = 0;
      bus.btn_right = 0;
      wait_idle(n);
      chk("pri busy_done", n, 2);
      chk("pri cells", dut_pack(), mpack());
      void'(model_move(1));
      e1 = mpack();
      bus.btn_right = 1;
      @(negedge CLK);
      bus.btn_right = 0;
      @(negedge CLK);
      bus.tick = 1;
      @(negedge CLK);
      bus.tick = 0;
      chk("pend idle", bus.busy, 0);
      chk("pend right", dut_pack(), e1);
      void'(model_move(3));
      @(negedge CLK);
      chk("pend served", bus.busy, 1);
      wait_idle(n);
      chk("pend down", dut_pack(), mpack());
      bus.btn_left = 1;
      @(negedge CLK);
      bus.btn_left = 0;
      #2 reset = 0;
      #1;
      chk("async cells", dut_pack(), 0);
      chk("async busy", bus.busy, 1);
      chk("async placed", bus.placed, 1);
      @(negedge CLK);
      do_reset();
      mb = 128'hFF;
      do_spawn(4, "go_spawn");
      mb = '0;
      bus.shape = 0;
      bus.spawn = 1;
      bus.btn_left = 1;
      bus.tick = 1;
      @(negedge CLK);
      clear_inputs();
      repeat (5) @(negedge CLK);
      chk("go cells", dut_pack(), mpack());
      chk("go sticky", bus.game_over, 1);
      chk("go busy", bus.busy, 1);
`ifdef TETROMINO_MOVER_HARD_DROP_EN
      do_reset();
      mb = '0;
      do_spawn(0, "drop_spawn");
      do_req(4, "drop");
      chk("drop const", dut_pack(), {3'd2,4'd15,3'd3,4'd15,3'd4,4'd15,3'd5,4'd15});
`endif
      do_reset();
      mb = '0;
      for (int t = 0; t < 300; t++) begin
         if (dead) begin
            do_reset();
            mb = '0;
         end
         if (!live) do_spawn(int'($urandom_range(0, 7)), "rnd_spawn");
         else begin
            r = int'($urandom_range(0, 5));
            do_req(r >= 3 ? 3 : r, "rnd_move");
         end
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
